coproc_arbiter: RTL

COPROC_ARBITER -- requirements
Module: coproc_arbiter

---
 rtl/coproc_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/coproc_arbiter.sv
// Round-robin arbiter that shares one coprocessor unit among N_REQ requesters,
// with a per-job timeout that aborts a stalled coprocessor.
module coproc_arbiter #(
    parameter int N_REQ   = 4,
    parameter int OP_W    = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*OP_W-1:0]    req_op,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         resp_valid,
    output logic [DATA_W-1:0]        resp_data,
    output logic                     resp_err,
    output logic                     cop_start,
    output logic [OP_W-1:0]          cop_op,
    output logic [DATA_W-1:0]        cop_data,
    input  logic                     cop_done,
    input  logic [DATA_W-1:0]        cop_result,
    output logic                     busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W:0]     sum;
    logic               found;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [IDX_W-1:0]   next_ptr;

    // Scan requesters starting at rr_ptr so the last winner ends up with lowest priority.
    always_comb begin
        win   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    assign cnt_inc  = cnt + 1'b1;
    assign next_ptr = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            idx        <= '0;
            cnt        <= '0;
            gnt        <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            cop_start  <= 1'b0;
            cop_op     <= '0;
            cop_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        idx       <= win;
                        gnt       <= N_REQ'(1) << win;
                        cop_op    <= req_op[int'(win)*OP_W +: OP_W];
                        cop_data  <= req_data[int'(win)*DATA_W +: DATA_W];
                        cop_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cop_start <= 1'b0;
                    cnt       <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // A completion arriving on the timeout cycle still counts as success.
                    if (cop_done) begin
                        resp_data  <= cop_result;
                        resp_err   <= 1'b0;
                        resp_valid <= gnt;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CNT_W'(TIMEOUT)) begin
                            resp_data  <= '0;
                            resp_err   <= 1'b1;
                            resp_valid <= gnt;
                            state      <= RESP;
                        end
                    end
                end
                RESP: begin
                    resp_valid <= '0;
                    gnt        <= '0;
                    rr_ptr     <= next_ptr;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
